// File: rtl/chip_driver_pkg.sv
// Shared types and helpers for the chip burst driver.
//   state_t    : driver FSM states
//   beatWidth  : width of a beat counter able to index BL beats
//   wrapColumn : sequential column wrap inside a BL-aligned window
package chip_driver_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DRAIN = 2'd2,
        RESP  = 2'd3
    } state_t;

    // A one-beat burst still needs a one-bit counter so the vectors stay legal.
    function automatic int beatWidth(input int bl);
        return (bl > 1) ? $clog2(bl) : 1;
    endfunction

    // The low log2(BL) bits walk (start + beat) mod BL while the upper bits
    // keep the BL-aligned window fixed; BL must be a power of two.
    function automatic logic [31:0] wrapColumn(input logic [31:0] col,
                                               input logic [31:0] beat,
                                               input int          bl);
        logic [31:0] mask;
        mask = 32'(bl - 1);
        return (col & ~mask) | ((col + beat) & mask);
    endfunction

endpackage

// File: rtl/read_capture_pipe.sv
// Delay line that tells the read-data buffer when and where to capture.
// Each read beat enters as {valid, beat index} in its address cycle and
// leaves DEPTH cycles later, which is when that beat's data is on dqout.
// Ports:
//   clk, reset : clock and synchronous active-high reset (flushes the line)
//   i_valid    : a read beat address is being driven this cycle
//   i_beat     : index of that beat
//   o_valid    : capture enable for the read-data buffer
//   o_beat     : buffer slot to write
module read_capture_pipe #(
    parameter int DEPTH  = 1,
    parameter int BEAT_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_valid,
    input  logic [BEAT_W-1:0] i_beat,
    output logic              o_valid,
    output logic [BEAT_W-1:0] o_beat
);

    logic              r_valid [DEPTH];
    logic [BEAT_W-1:0] r_beat  [DEPTH];

    // Plain shift register; reset drops every in-flight capture so a burst
    // aborted by reset can never write into a later request's buffer.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_valid[i] <= 1'b0;
                r_beat[i]  <= '0;
            end
        end else begin
            r_valid[0] <= i_valid;
            r_beat[0]  <= i_beat;
            for (int i = 1; i < DEPTH; i++) begin
                r_valid[i] <= r_valid[i-1];
                r_beat[i]  <= r_beat[i-1];
            end
        end
    end

    assign o_valid = r_valid[DEPTH-1];
    assign o_beat  = r_beat[DEPTH-1];

endmodule

// File: rtl/chip_burst_driver.sv
// Requester-side burst driver for a per-bank Chip array. Accepts one burst
// at a time, drives BL sequential beats onto the addressed bank and, for
// reads, assembles the returned dqout beats into one response word.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   req_*               : request (valid/ready, write flag, bg, ba, row, col, wdata)
//   rsp_*               : response (valid/ready, write echo, read data)
//   rd_o_wr/dqin/row/column : per-bank command outputs, zero unless selected in BURST
//   dqout               : per-bank read data inputs
module chip_burst_driver
    import chip_driver_pkg::*;
#(
    parameter int BGWIDTH      = 2,
    parameter int BAWIDTH      = 2,
    parameter int ADDRWIDTH    = 17,
    parameter int COLWIDTH     = 10,
    parameter int DEVICE_WIDTH = 4,
    parameter int BL           = 8,
    parameter int RDLAT        = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic                       req_write,
    input  logic [BGWIDTH-1:0]         req_bg,
    input  logic [BAWIDTH-1:0]         req_ba,
    input  logic [ADDRWIDTH-1:0]       req_row,
    input  logic [COLWIDTH-1:0]        req_col,
    input  logic [BL*DEVICE_WIDTH-1:0] req_wdata,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic                       rsp_write,
    output logic [BL*DEVICE_WIDTH-1:0] rsp_rdata,
    output logic                       rd_o_wr [1<<BGWIDTH][1<<BAWIDTH],
    output logic [DEVICE_WIDTH-1:0]    dqin    [1<<BGWIDTH][1<<BAWIDTH],
    input  logic [DEVICE_WIDTH-1:0]    dqout   [1<<BGWIDTH][1<<BAWIDTH],
    output logic [ADDRWIDTH-1:0]       row     [1<<BGWIDTH][1<<BAWIDTH],
    output logic [COLWIDTH-1:0]        column  [1<<BGWIDTH][1<<BAWIDTH]
);

    localparam int                BEAT_W    = beatWidth(BL);
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BL - 1);

    state_t                       r_state;
    state_t                       w_nextState;
    logic                         r_write;
    logic [BGWIDTH-1:0]           r_bg;
    logic [BAWIDTH-1:0]           r_ba;
    logic [ADDRWIDTH-1:0]         r_row;
    logic [COLWIDTH-1:0]          r_col;
    logic [BL*DEVICE_WIDTH-1:0]   r_wdata;
    logic [BL*DEVICE_WIDTH-1:0]   r_rdata;
    logic [BEAT_W-1:0]            r_beat;

    logic                         w_idle;
    logic                         w_burstActive;
    logic                         w_issueRead;
    logic                         w_rspValid;
    logic                         w_accept;
    logic                         w_capValid;
    logic [BEAT_W-1:0]            w_capBeat;
    logic [DEVICE_WIDTH-1:0]      w_dqSel;
    logic [DEVICE_WIDTH-1:0]      w_wbeat;
    logic [COLWIDTH-1:0]          w_column;

    // State register; reset always lands in IDLE, aborting any burst.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state and control decode. A read with zero read latency has its
    // last beat captured on the same edge that ends BURST, so it can skip
    // DRAIN; otherwise DRAIN waits for the last slot to leave the pipe.
    always_comb begin
        w_nextState   = r_state;
        w_idle        = 1'b0;
        w_burstActive = 1'b0;
        w_issueRead   = 1'b0;
        w_rspValid    = 1'b0;
        case (r_state)
            IDLE: begin
                w_idle = 1'b1;
                if (req_valid) begin
                    w_nextState = BURST;
                end
            end
            BURST: begin
                w_burstActive = 1'b1;
                w_issueRead   = !r_write;
                if (r_beat == BEAT_LAST) begin
                    w_nextState = (r_write || RDLAT == 0) ? RESP : DRAIN;
                end
            end
            DRAIN: begin
                if (w_capValid && w_capBeat == BEAT_LAST) begin
                    w_nextState = RESP;
                end
            end
            RESP: begin
                w_rspValid = 1'b1;
                if (rsp_ready) begin
                    w_nextState = IDLE;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    assign w_accept  = w_idle && req_valid;
    assign req_ready = w_idle && !reset;
    assign rsp_valid = w_rspValid;
    assign rsp_write = r_write;
    assign rsp_rdata = r_rdata;

    // Request latch, beat counter and read-data buffer. The buffer is cleared
    // on accept so a write response always carries zero data.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_write <= 1'b0;
            r_bg    <= '0;
            r_ba    <= '0;
            r_row   <= '0;
            r_col   <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_beat  <= '0;
        end else begin
            if (w_accept) begin
                r_write <= req_write;
                r_bg    <= req_bg;
                r_ba    <= req_ba;
                r_row   <= req_row;
                r_col   <= req_col;
                r_wdata <= req_wdata;
                r_rdata <= '0;
                r_beat  <= '0;
            end else if (w_burstActive) begin
                r_beat <= r_beat + 1'b1;
            end
            if (w_capValid) begin
                r_rdata[w_capBeat*DEVICE_WIDTH +: DEVICE_WIDTH] <= w_dqSel;
            end
        end
    end

    // With zero read latency the data is on dqout during the address cycle,
    // so the capture enable is simply the read-issue strobe itself.
    if (RDLAT > 0) begin : gCapPipe
        read_capture_pipe #(
            .DEPTH  (RDLAT),
            .BEAT_W (BEAT_W)
        ) uCapPipe (
            .clk     (clk),
            .reset   (reset),
            .i_valid (w_issueRead),
            .i_beat  (r_beat),
            .o_valid (w_capValid),
            .o_beat  (w_capBeat)
        );
    end else begin : gCapDirect
        assign w_capValid = w_issueRead;
        assign w_capBeat  = r_beat;
    end

    assign w_dqSel  = dqout[r_bg][r_ba];
    assign w_wbeat  = r_wdata[r_beat*DEVICE_WIDTH +: DEVICE_WIDTH];
    assign w_column = COLWIDTH'(wrapColumn(32'(r_col), 32'(r_beat), BL));

    // Per-bank fan-out: only the latched bank sees anything, and only in BURST.
    for (genvar g = 0; g < (1 << BGWIDTH); g++) begin : gBg
        for (genvar b = 0; b < (1 << BAWIDTH); b++) begin : gBa
            logic w_sel;
            assign w_sel        = w_burstActive && (r_bg == BGWIDTH'(g)) && (r_ba == BAWIDTH'(b));
            assign rd_o_wr[g][b] = w_sel && r_write;
            assign dqin[g][b]    = (w_sel && r_write) ? w_wbeat : '0;
            assign row[g][b]     = w_sel ? r_row : '0;
            assign column[g][b]  = w_sel ? w_column : '0;
        end
    end

endmodule

// File: tb/tb_chip_burst_driver.sv
// Directed bench for chip_burst_driver. Four instances share one clock and
// reset with RDLAT = 0..3 (instance index = RDLAT); each has a simple bank
// memory that stores write beats and returns read data RDLAT cycles after
// the column address.
module tb_chip_burst_driver;

    localparam int BGW = 2;
    localparam int BAW = 2;
    localparam int AW  = 17;
    localparam int CW  = 10;
    localparam int DW  = 4;
    localparam int BL  = 8;
    localparam int NG  = 4;
    localparam int NB  = 4;
    localparam int NI  = 4;
    localparam int BD  = BL * DW;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int testsRun    = 0;
    int testsFailed = 0;

    logic           reqValid [NI];
    logic           reqReady [NI];
    logic           reqWrite [NI];
    logic [BGW-1:0] reqBg    [NI];
    logic [BAW-1:0] reqBa    [NI];
    logic [AW-1:0]  reqRow   [NI];
    logic [CW-1:0]  reqCol   [NI];
    logic [BD-1:0]  reqWdata [NI];
    logic           rspValid [NI];
    logic           rspReady [NI];
    logic           rspWrite [NI];
    logic [BD-1:0]  rspRdata [NI];

    logic           rdOWr   [NI][NG][NB];
    logic [DW-1:0]  dqinOut [NI][NG][NB];
    logic [AW-1:0]  rowOut  [NI][NG][NB];
    logic [CW-1:0]  colOut  [NI][NG][NB];

    // One driver per read latency, each with its own bank memory model.
    for (genvar k = 0; k < NI; k++) begin : gDut
        logic          lRdOWr [NG][NB];
        logic [DW-1:0] lDqin  [NG][NB];
        logic [DW-1:0] lDqout [NG][NB];
        logic [AW-1:0] lRow   [NG][NB];
        logic [CW-1:0] lCol   [NG][NB];
        logic [DW-1:0] mem    [NG*NB*1024];
        logic [CW-1:0] colHist [4];
        logic [CW-1:0] rdCol;

        chip_burst_driver #(
            .BGWIDTH(BGW), .BAWIDTH(BAW), .ADDRWIDTH(AW), .COLWIDTH(CW),
            .DEVICE_WIDTH(DW), .BL(BL), .RDLAT(k)
        ) uDut (
            .clk       (clk),
            .reset     (reset),
            .req_valid (reqValid[k]),
            .req_ready (reqReady[k]),
            .req_write (reqWrite[k]),
            .req_bg    (reqBg[k]),
            .req_ba    (reqBa[k]),
            .req_row   (reqRow[k]),
            .req_col   (reqCol[k]),
            .req_wdata (reqWdata[k]),
            .rsp_valid (rspValid[k]),
            .rsp_ready (rspReady[k]),
            .rsp_write (rspWrite[k]),
            .rsp_rdata (rspRdata[k]),
            .rd_o_wr   (lRdOWr),
            .dqin      (lDqin),
            .dqout     (lDqout),
            .row       (lRow),
            .column    (lCol)
        );

        for (genvar g = 0; g < NG; g++) begin : gG
            for (genvar b = 0; b < NB; b++) begin : gB
                assign rdOWr[k][g][b]   = lRdOWr[g][b];
                assign dqinOut[k][g][b] = lDqin[g][b];
                assign rowOut[k][g][b]  = lRow[g][b];
                assign colOut[k][g][b]  = lCol[g][b];
            end
        end

        // Bank memory: store write beats; remember the target bank's column
        // history so reads can be answered RDLAT cycles later.
        always @(posedge clk) begin
            for (int g = 0; g < NG; g++) begin
                for (int b = 0; b < NB; b++) begin
                    if (lRdOWr[g][b]) begin
                        mem[(g*NB + b)*1024 + int'(lCol[g][b])] <= lDqin[g][b];
                    end
                end
            end
            colHist[0] <= lCol[reqBg[k]][reqBa[k]];
            for (int i = 1; i < 4; i++) begin
                colHist[i] <= colHist[i-1];
            end
        end

        assign rdCol = (k == 0) ? lCol[reqBg[k]][reqBa[k]] : colHist[(k > 0) ? k - 1 : 0];

        // Banks other than the requested one return a filler nibble so a
        // wrong dqout mux shows up as bad data.
        always_comb begin
            for (int g = 0; g < NG; g++) begin
                for (int b = 0; b < NB; b++) begin
                    lDqout[g][b] = 4'hA;
                    if (g == int'(reqBg[k]) && b == int'(reqBa[k])) begin
                        lDqout[g][b] = mem[(g*NB + b)*1024 + int'(rdCol)];
                    end
                end
            end
        end
    end

    // Number of banks of instance d driving anything, skipping bank (exG, exB).
    function automatic int activeBanks(input int d, input int exG, input int exB);
        int n = 0;
        for (int g = 0; g < NG; g++) begin
            for (int b = 0; b < NB; b++) begin
                if (!(g == exG && b == exB) &&
                    (rdOWr[d][g][b] || dqinOut[d][g][b] != 0 ||
                     rowOut[d][g][b] != 0 || colOut[d][g][b] != 0)) begin
                    n++;
                end
            end
        end
        return n;
    endfunction

    // Present a request from a falling edge; returns in the first burst cycle.
    task automatic startRequest(input int d, input logic wr,
                                input logic [BGW-1:0] bg, input logic [BAW-1:0] ba,
                                input logic [AW-1:0] rw, input logic [CW-1:0] col,
                                input logic [BD-1:0] wd);
        int waitCycles = 0;
        reqWrite[d] = wr;
        reqBg[d]    = bg;
        reqBa[d]    = ba;
        reqRow[d]   = rw;
        reqCol[d]   = col;
        reqWdata[d] = wd;
        while (!reqReady[d] && waitCycles < 20) begin
            @(negedge clk);
            waitCycles++;
        end
        if (!reqReady[d]) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL start_request dut%0d: req_ready got %b expected 1", d, reqReady[d]);
        end
        reqValid[d] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reqValid[d] = 1'b0;
    endtask

    // Count cycles from the first burst cycle (1) until rsp_valid; -1 on timeout.
    task automatic runToResponse(input int d, output int lat);
        lat = 1;
        while (!rspValid[d] && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        if (!rspValid[d]) lat = -1;
    endtask

    task automatic finishResponse(input int d);
        rspReady[d] = 1'b1;
        @(negedge clk);
        rspReady[d] = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        for (int d = 0; d < NI; d++) begin
            testsRun++;
            if (reqReady[d] !== 1'b0 || rspValid[d] !== 1'b0 || rspWrite[d] !== 1'b0 ||
                rspRdata[d] !== '0 || activeBanks(d, -1, -1) != 0) begin
                testsFailed++;
                $display("[TB] FAIL reset_state dut%0d: ready %b valid %b write %b rdata %h banks %0d, expected all 0",
                         d, reqReady[d], rspValid[d], rspWrite[d], rspRdata[d], activeBanks(d, -1, -1));
            end
        end
        reset = 1'b0;
        @(negedge clk);
        for (int d = 0; d < NI; d++) begin
            testsRun++;
            if (reqReady[d] !== 1'b1) begin
                testsFailed++;
                $display("[TB] FAIL ready_after_reset dut%0d: got %b expected 1", d, reqReady[d]);
            end
        end
    endtask

    task automatic test_write();
        logic [CW-1:0] expCol [BL];
        expCol = '{10'h004, 10'h005, 10'h006, 10'h007, 10'h000, 10'h001, 10'h002, 10'h003};
        startRequest(1, 1'b1, 2'd1, 2'd2, 17'h1ABCD, 10'h004, 32'h76543210);
        for (int i = 0; i < BL; i++) begin
            testsRun++;
            if (rdOWr[1][1][2] !== 1'b1 || colOut[1][1][2] !== expCol[i] ||
                dqinOut[1][1][2] !== 4'(i) || rowOut[1][1][2] !== 17'h1ABCD) begin
                testsFailed++;
                $display("[TB] FAIL write_beat%0d: wr %b col %h dq %h row %h expected 1 %h %h 1abcd",
                         i, rdOWr[1][1][2], colOut[1][1][2], dqinOut[1][1][2], rowOut[1][1][2], expCol[i], 4'(i));
            end
            testsRun++;
            if (activeBanks(1, 1, 2) != 0 || rspValid[1] !== 1'b0) begin
                testsFailed++;
                $display("[TB] FAIL write_isolation beat%0d: other banks %0d rsp_valid %b expected 0 0",
                         i, activeBanks(1, 1, 2), rspValid[1]);
            end
            @(negedge clk);
        end
        testsRun++;
        if (rspValid[1] !== 1'b1 || rspWrite[1] !== 1'b1 || rspRdata[1] !== 32'h0 ||
            activeBanks(1, -1, -1) != 0) begin
            testsFailed++;
            $display("[TB] FAIL write_response T0+9: valid %b write %b rdata %h banks %0d expected 1 1 0 0",
                     rspValid[1], rspWrite[1], rspRdata[1], activeBanks(1, -1, -1));
        end
        finishResponse(1);
        testsRun++;
        if (rspValid[1] !== 1'b0 || reqReady[1] !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL write_idle: valid %b ready %b expected 0 1", rspValid[1], reqReady[1]);
        end
    endtask

    task automatic test_read();
        rspReady[1] = 1'b1;
        startRequest(1, 1'b0, 2'd1, 2'd2, 17'h1ABCD, 10'h004, 32'h0);
        testsRun++;
        if (colOut[1][1][2] !== 10'h004 || rowOut[1][1][2] !== 17'h1ABCD) begin
            testsFailed++;
            $display("[TB] FAIL read_beat0: col %h row %h expected 004 1abcd", colOut[1][1][2], rowOut[1][1][2]);
        end
        for (int n = 1; n < BL + 2; n++) begin
            testsRun++;
            if (rspValid[1] !== 1'b0 || rdOWr[1][1][2] !== 1'b0) begin
                testsFailed++;
                $display("[TB] FAIL read_early cycle%0d: rsp_valid %b rd_o_wr %b expected 0 0", n, rspValid[1], rdOWr[1][1][2]);
            end
            @(negedge clk);
        end
        testsRun++;
        if (rspValid[1] !== 1'b1 || rspRdata[1] !== 32'h76543210 || rspWrite[1] !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL read_response T0+10: valid %b rdata %h write %b expected 1 76543210 0",
                     rspValid[1], rspRdata[1], rspWrite[1]);
        end
        @(negedge clk);
        rspReady[1] = 1'b0;
        testsRun++;
        if (rspValid[1] !== 1'b0 || reqReady[1] !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL read_idle: valid %b ready %b expected 0 1", rspValid[1], reqReady[1]);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        startRequest(1, 1'b1, 2'd3, 2'd0, 17'h00005, 10'h3F9, 32'hDEADBEEF);
        testsRun++;
        if (colOut[1][3][0] !== 10'h3F9) begin
            testsFailed++;
            $display("[TB] FAIL bp_first_column: got %h expected 3f9", colOut[1][3][0]);
        end
        repeat (BL - 1) @(negedge clk);
        testsRun++;
        if (colOut[1][3][0] !== 10'h3F8 || dqinOut[1][3][0] !== 4'hD) begin
            testsFailed++;
            $display("[TB] FAIL bp_last_beat: col %h dq %h expected 3f8 d", colOut[1][3][0], dqinOut[1][3][0]);
        end
        @(negedge clk);
        reqWrite[1] = 1'b0;
        reqValid[1] = 1'b1;
        for (int c = 0; c < 5; c++) begin
            testsRun++;
            if (rspValid[1] !== 1'b1 || rspWrite[1] !== 1'b1 || rspRdata[1] !== 32'h0 || reqReady[1] !== 1'b0) begin
                testsFailed++;
                $display("[TB] FAIL bp_hold%0d: valid %b write %b rdata %h ready %b expected 1 1 0 0",
                         c, rspValid[1], rspWrite[1], rspRdata[1], reqReady[1]);
            end
            @(negedge clk);
        end
        finishResponse(1);
        testsRun++;
        if (rspValid[1] !== 1'b0 || reqReady[1] !== 1'b1 || activeBanks(1, -1, -1) != 0) begin
            testsFailed++;
            $display("[TB] FAIL bp_idle_gap: valid %b ready %b banks %0d expected 0 1 0",
                     rspValid[1], reqReady[1], activeBanks(1, -1, -1));
        end
        @(posedge clk);
        @(negedge clk);
        reqValid[1] = 1'b0;
        testsRun++;
        if (colOut[1][3][0] !== 10'h3F9 || rowOut[1][3][0] !== 17'h00005 || rdOWr[1][3][0] !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL bp_second_start: col %h row %h wr %b expected 3f9 00005 0",
                     colOut[1][3][0], rowOut[1][3][0], rdOWr[1][3][0]);
        end
        runToResponse(1, lat);
        testsRun++;
        if (lat != 10 || rspRdata[1] !== 32'hDEADBEEF) begin
            testsFailed++;
            $display("[TB] FAIL bp_second_read: latency %0d rdata %h expected 10 deadbeef", lat, rspRdata[1]);
        end
        finishResponse(1);
    endtask

    task automatic test_reset_mid_burst();
        int pulses = 0;
        int rspSeen = 0;
        startRequest(1, 1'b1, 2'd0, 2'd1, 17'h00123, 10'h010, 32'h13579BDF);
        repeat (3) @(negedge clk);
        testsRun++;
        if (rdOWr[1][0][1] !== 1'b1 || dqinOut[1][0][1] !== 4'h9) begin
            testsFailed++;
            $display("[TB] FAIL abort_beat3: wr %b dq %h expected 1 9", rdOWr[1][0][1], dqinOut[1][0][1]);
        end
        reset = 1'b1;
        @(negedge clk);
        testsRun++;
        if (activeBanks(1, -1, -1) != 0 || reqReady[1] !== 1'b0 || rspValid[1] !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL abort_in_reset: banks %0d ready %b valid %b expected 0 0 0",
                     activeBanks(1, -1, -1), reqReady[1], rspValid[1]);
        end
        reset = 1'b0;
        @(negedge clk);
        testsRun++;
        if (reqReady[1] !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL abort_ready: got %b expected 1", reqReady[1]);
        end
        for (int c = 0; c < 12; c++) begin
            for (int g = 0; g < NG; g++) begin
                for (int b = 0; b < NB; b++) begin
                    if (rdOWr[1][g][b] === 1'b1) pulses++;
                end
            end
            if (rspValid[1] === 1'b1) rspSeen++;
            @(negedge clk);
        end
        testsRun++;
        if (pulses != 0 || rspSeen != 0) begin
            testsFailed++;
            $display("[TB] FAIL abort_quiet: write pulses %0d responses %0d expected 0 0", pulses, rspSeen);
        end
    endtask

    task automatic test_rdlat_sweep();
        logic [BGW-1:0] tBg  [NI];
        logic [BAW-1:0] tBa  [NI];
        logic [AW-1:0]  tRow [NI];
        logic [CW-1:0]  tCol [NI];
        logic [BD-1:0]  tDat [NI];
        int lat;
        tBg  = '{2'd2, 2'd0, 2'd3, 2'd1};
        tBa  = '{2'd3, 2'd0, 2'd3, 2'd1};
        tRow = '{17'h0F0F0, 17'h10001, 17'h1FFFF, 17'h00000};
        tCol = '{10'h1A5, 10'h007, 10'h3FF, 10'h200};
        tDat = '{32'hA5C3E1F0, 32'h0F1E2D3C, 32'h89ABCDEF, 32'h55AA33CC};
        for (int d = 0; d < NI; d++) begin
            startRequest(d, 1'b1, tBg[d], tBa[d], tRow[d], tCol[d], tDat[d]);
            runToResponse(d, lat);
            testsRun++;
            if (lat != BL + 1) begin
                testsFailed++;
                $display("[TB] FAIL sweep_write_latency rdlat%0d: got %0d expected %0d", d, lat, BL + 1);
            end
            finishResponse(d);
            startRequest(d, 1'b0, tBg[d], tBa[d], tRow[d], tCol[d], 32'h0);
            runToResponse(d, lat);
            testsRun++;
            if (lat != BL + d + 1) begin
                testsFailed++;
                $display("[TB] FAIL sweep_read_latency rdlat%0d: got %0d expected %0d", d, lat, BL + d + 1);
            end
            testsRun++;
            if (rspRdata[d] !== tDat[d] || rspWrite[d] !== 1'b0) begin
                testsFailed++;
                $display("[TB] FAIL sweep_read_data rdlat%0d: rdata %h write %b expected %h 0",
                         d, rspRdata[d], rspWrite[d], tDat[d]);
            end
            finishResponse(d);
        end
    endtask

    initial begin
        reset = 1'b1;
        for (int d = 0; d < NI; d++) begin
            reqValid[d] = 1'b0;
            reqWrite[d] = 1'b0;
            reqBg[d]    = '0;
            reqBa[d]    = '0;
            reqRow[d]   = '0;
            reqCol[d]   = '0;
            reqWdata[d] = '0;
            rspReady[d] = 1'b0;
        end
        test_reset();
        test_write();
        test_read();
        test_back_to_back();
        test_reset_mid_burst();
        test_rdlat_sweep();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
